ring_entropy_sampler: RTL and testbench

RING_ENTROPY_SAMPLER -- requirements
Module: ring_entropy_sampler

---
 rtl/ring_pkg.sv | 14 +
 rtl/rnd_fifo.sv | 65 ++++++
 rtl/ring_entropy_sampler.sv | 142 ++++++++++++++
 tb/tb_ring_entropy_sampler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and constants for the ring-oscillator entropy sampler.
// Holds the FSM state encoding, default warm-up length and word width.
package ring_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    localparam int WARMUP_DEFAULT = 16;
    localparam int WORD_W = 32;

endpackage

// File: rtl/rnd_fifo.sv
// Synchronous word FIFO with level count and sticky drop flag.
// A push while full is only taken when a pop frees a slot that cycle.
module rnd_fifo
    import ring_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     clr_ovf,
    output logic [WORD_W-1:0]        head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign valid   = !empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(do_push) - LW'(do_pop);
            // a dropped word beats a same-cycle clear
            if (push && !do_push) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ring_entropy_sampler.sv
// Ring-oscillator entropy sampler: warm-up FSM, synchronizer, divider,
// optional von Neumann debiaser and 32-bit word packer feeding a FIFO.
module ring_entropy_sampler
    import ring_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int WARMUP_CYCLES = WARMUP_DEFAULT
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rstn_i,
    input  logic                        enable_i,
    input  logic                        ring_clk_i,
    output logic                        ring_start_o,
    input  logic [7:0]                  sample_div_i,
    input  logic                        debias_en_i,
    output logic [WORD_W-1:0]           rnd_data_o,
    output logic                        rnd_valid_o,
    input  logic                        rnd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o,
    input  logic                        clr_ovf_i
);

    localparam int WW = $clog2(WARMUP_CYCLES + 1);

    state_t              state;
    logic [SYNC_STAGES-1:0] sync;
    logic [WW-1:0]       warm_cnt;
    logic [7:0]          div_cnt;
    logic [4:0]          bit_cnt;
    logic [WORD_W-1:0]   word;
    logic                pair_vld;
    logic                pair_bit;
    logic                run;
    logic                tick;
    logic                smp;
    logic                accept;
    logic                acc_bit;
    logic                push;
    logic [WORD_W-1:0]   push_word;

    assign smp  = sync[SYNC_STAGES-1];
    assign run  = (state == ST_RUN) && enable_i;
    // >= keeps a shrinking divisor from waiting a full 8-bit wrap
    assign tick = run && (div_cnt >= sample_div_i);

    always_comb begin
        accept  = 1'b0;
        acc_bit = smp;
        if (tick) begin
            if (!debias_en_i) begin
                accept = 1'b1;
            end else if (pair_vld && (pair_bit != smp)) begin
                accept  = 1'b1;
                acc_bit = pair_bit;
            end
        end
    end

    assign push = accept && (bit_cnt == 5'd31);

    always_comb begin
        push_word             = word;
        push_word[WORD_W-1]   = acc_bit;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state        <= ST_IDLE;
            ring_start_o <= 1'b0;
            warm_cnt     <= '0;
            sync         <= '0;
        end else begin
            sync <= (sync << 1) | SYNC_STAGES'(ring_clk_i);
            if (!enable_i) begin
                state        <= ST_IDLE;
                ring_start_o <= 1'b0;
                warm_cnt     <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state        <= ST_WARMUP;
                        ring_start_o <= 1'b1;
                        warm_cnt     <= '0;
                    end
                    ST_WARMUP: begin
                        if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
                            state <= ST_RUN;
                        end else begin
                            warm_cnt <= warm_cnt + WW'(1);
                        end
                    end
                    ST_RUN: begin
                        ring_start_o <= 1'b1;
                    end
                    default: begin
                        state        <= ST_IDLE;
                        ring_start_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // partial word, pair and divider only live while sampling
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i || !run) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word     <= '0;
            pair_vld <= 1'b0;
            pair_bit <= 1'b0;
        end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (tick && debias_en_i) begin
                pair_vld <= !pair_vld;
                pair_bit <= smp;
            end
            if (accept) begin
                word[bit_cnt] <= acc_bit;
                bit_cnt       <= bit_cnt + 5'd1;
            end
        end
    end

    rnd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (wb_clk_i),
        .rstn     (wb_rstn_i),
        .push     (push),
        .push_data(push_word),
        .pop      (rnd_ready_i),
        .clr_ovf  (clr_ovf_i),
        .head     (rnd_data_o),
        .valid    (rnd_valid_o),
        .level    (fifo_level_o),
        .ovf      (overflow_o)
    );

endmodule

// File: tb/tb_ring_entropy_sampler.sv
// Bench for ring_entropy_sampler: forced sample streams, scoreboard
// of expected FIFO words, FIFO full/overflow and reset corner cases.
module tb_ring_entropy_sampler;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        ring_clk;
    logic        ring_start;
    logic [7:0]  div = 8'd3;
    logic        debias = 1'b0;
    logic [31:0] data;
    logic        valid;
    logic        ready = 1'b0;
    logic [2:0]  level;
    logic        ovf;
    logic        clr_ovf = 1'b0;

    logic ring_osc = 1'b0;
    logic ring_force = 1'b0;
    logic ring_free = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic        stream[$];

    typedef struct {
        logic        deb;
        logic [7:0]  dv;
        logic [31:0] w;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] wl[5];

    assign ring_clk = ring_free ? ring_osc : ring_force;

    always #5 clk = ~clk;
    always #50 ring_osc = ~ring_osc;

    ring_entropy_sampler dut (
        .wb_clk_i    (clk),
        .wb_rstn_i   (rstn),
        .enable_i    (enable),
        .ring_clk_i  (ring_clk),
        .ring_start_o(ring_start),
        .sample_div_i(div),
        .debias_en_i (debias),
        .rnd_data_o  (data),
        .rnd_valid_o (valid),
        .rnd_ready_i (ready),
        .fifo_level_o(level),
        .overflow_o  (ovf),
        .clr_ovf_i   (clr_ovf)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // every accepted transfer is matched against the oldest expected word
    always @(negedge clk) begin
        if (rstn && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: got %h, want no word", data);
            end else begin
                check("sb_word", data, exp_q.pop_front());
            end
        end
    end

    task automatic add_bits(logic deb, logic [31:0] w, int n);
        for (int i = 0; i < n; i++) begin
            if (!deb) begin
                stream.push_back(w[i]);
            end else begin
                if (i % 4 == 3) begin
                    stream.push_back(i[2]);
                    stream.push_back(i[2]);
                end
                stream.push_back(w[i]);
                stream.push_back(!w[i]);
            end
        end
    endtask

    // RUN begins 16 clocks after enable; each bit is set mid-period
    task automatic run_stream(logic [7:0] d, logic deb);
        int half;
        half = (int'(d) + 1) / 2;
        div = d;
        debias = deb;
        ring_free = 1'b0;
        enable = 1'b1;
        step();
        repeat (16 + half) step();
        while (stream.size() > 0) begin
            ring_force = stream.pop_front();
            repeat (int'(d) + 1) step();
        end
        repeat (2) step();
        enable = 1'b0;
        repeat (2) step();
    endtask

    task automatic drain();
        int k;
        ready = 1'b1;
        k = 0;
        while (level != 0 && k < 40) begin
            step();
            k++;
        end
        ready = 1'b0;
        check("drain_level", 32'(level), 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_start"}, 32'(ring_start), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_data"}, data, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{deb: 1'b0, dv: 8'd7, w: 32'hA5C3_0F1E};
        vecs[1] = '{deb: 1'b1, dv: 8'd7, w: 32'h1234_5676};
        vecs[2] = '{deb: 1'b0, dv: 8'd9, w: 32'hFFFF_0000};
        vecs[3] = '{deb: 1'b1, dv: 8'd9, w: 32'h8000_0001};
        wl[0] = 32'hDEAD_BEEF;
        wl[1] = 32'h0123_4567;
        wl[2] = 32'hCAFE_F00D;
        wl[3] = 32'h5555_AAAA;
        wl[4] = 32'h0F0F_3C3C;

        repeat (3) step();
        check_reset("rst");
        rstn = 1'b1;
        step();

        // free-running ring, 10-clock period, sample every 4 clocks
        div = 8'd3;
        ring_free = 1'b1;
        enable = 1'b1;
        check("start_before", 32'(ring_start), 32'd0);
        step();
        check("start_rise", 32'(ring_start), 32'd1);
        repeat (140) step();
        check("no_word_early", 32'(level), 32'd0);
        repeat (8) step();
        check("first_word", 32'(level), 32'd1);
        k = 0;
        while (level != 3 && k < 400) begin
            step();
            k++;
        end
        check("three_queued", 32'(level), 32'd3);
        rstn = 1'b0;
        enable = 1'b0;
        step();
        check_reset("midrun_rst");
        rstn = 1'b1;
        ring_free = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            stream.delete();
            add_bits(vecs[v].deb, vecs[v].w, 32);
            exp_q.push_back(vecs[v].w);
            ready = 1'b1;
            run_stream(vecs[v].dv, vecs[v].deb);
            check("vec_level", 32'(level), 32'd0);
            check("vec_sb", exp_q.size(), 32'd0);
            ready = 1'b0;
        end

        // five words into a four-deep FIFO with no consumer
        stream.delete();
        for (int i = 0; i < 5; i++) begin
            add_bits(1'b0, wl[i], 32);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(wl[i]);
        end
        run_stream(8'd7, 1'b0);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_head", data, wl[0]);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
        drain();

        // fifth push lands on a cycle with a simultaneous pop
        stream.delete();
        for (int i = 0; i < 5; i++) begin
            add_bits(1'b0, wl[i], 32);
            exp_q.push_back(wl[i]);
        end
        fork
            run_stream(8'd7, 1'b0);
            begin
                k = 0;
                while (level != 4 && k < 3000) begin
                    step();
                    k++;
                end
                check("full_reached", 32'(level), 32'd4);
                repeat (255) step();
                ready = 1'b1;
                step();
                ready = 1'b0;
                check("pp_level", 32'(level), 32'd4);
                check("pp_ovf", 32'(ovf), 32'd0);
            end
        join
        drain();

        // partial word must not survive an enable drop
        stream.delete();
        add_bits(1'b0, wl[2], 32);
        add_bits(1'b0, wl[3], 20);
        exp_q.push_back(wl[2]);
        run_stream(8'd7, 1'b0);
        check("drop_level", 32'(level), 32'd1);
        stream.delete();
        add_bits(1'b0, wl[4], 32);
        exp_q.push_back(wl[4]);
        run_stream(8'd7, 1'b0);
        check("reen_level", 32'(level), 32'd2);
        check("reen_head", data, wl[2]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
